clk_period_meter: RTL and testbench

- Measures the period and high time of a slow external or derived clock `sig_i`. Both results are counted in `clk_i` cycles.
- It is the measuring counterpart of the board clock-divider blocks: dividers generate slow clocks, this block checks them.
- Sits beside the CPU top. Results go to debug LEDs or the seven-segment path through a valid/ack handshake.

---
 rtl/clk_period_meter.sv | 171 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow signal sig_i,
// both counted in clk_i cycles, and hands results out over a valid/ack
// handshake.
// Optional stall detection is compiled in with `define CLK_METER_TIMEOUT_EN.
module clk_period_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    input  logic             meas_ack_i,
    output logic             meas_valid_o,
    output logic [CNT_W-1:0] meas_period_o,
    output logic [CNT_W-1:0] meas_high_o,
    output logic             overflow_o,
    output logic             overrun_o,
    output logic             stall_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_sat;
    logic             w_capture;
    logic             w_restart;
    logic             w_ack;
    logic             w_stall_hit;

    assign w_rise = r_s2 & ~r_s3;
    assign w_ack  = meas_valid_o & meas_ack_i;

    // Two-flop synchronizer plus history flop for rising-edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: the first rise arms measurement, later rises capture
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_MEAS;
                    w_restart    = 1'b1;
                end
            end
            ST_MEAS: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                    w_restart = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_stall_hit) begin
            w_state_next = ST_IDLE;
        end
    end

    // Period/high counters; the rise cycle itself counts as the first cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
            r_sat  <= 1'b0;
        end else if (w_restart) begin
            r_cnt  <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
            r_sat  <= 1'b0;
        end else if (r_state == ST_MEAS) begin
            if (r_cnt == CNT_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_s2 && (r_hcnt != CNT_MAX)) begin
                r_hcnt <= r_hcnt + CNT_W'(1);
            end
        end
    end

    // Result registers and valid/ack/overrun handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meas_valid_o  <= 1'b0;
            meas_period_o <= '0;
            meas_high_o   <= '0;
            overflow_o    <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            if (w_capture) begin
                meas_period_o <= r_cnt;
                meas_high_o   <= r_hcnt;
                overflow_o    <= r_sat;
                meas_valid_o  <= 1'b1;
            end else if (w_ack) begin
                meas_valid_o  <= 1'b0;
            end
            if (w_capture && meas_valid_o && !meas_ack_i) begin
                overrun_o <= 1'b1;
            end else if (w_ack) begin
                overrun_o <= 1'b0;
            end
        end
    end

`ifdef CLK_METER_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC) + 1;

    logic [STALL_W-1:0] r_stall_cnt;

    assign w_stall_hit = !w_rise && (r_stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    // Stall watchdog: restarts on every rise, flags and drops to IDLE on expiry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            stall_o     <= 1'b0;
        end else if (w_rise) begin
            r_stall_cnt <= '0;
            stall_o     <= 1'b0;
        end else if (w_stall_hit) begin
            r_stall_cnt <= '0;
            stall_o     <= 1'b1;
        end else begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_stall_hit      = 1'b0;
    assign stall_o          = 1'b0;
    assign w_unused_timeout = ^32'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter (CNT_W=8). The stimulus process plays
// sig_i one clock at a time and, at every rise, pushes the expected result for
// the interval that just ended; a monitor acks results and checks them.
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 8;
    localparam int          MAXV  = (1 << CNT_W) - 1;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic             ovf;
        logic             ovr;
    } exp_t;

    logic             clk_i;
    logic             rst_i;
    logic             sig_i;
    logic             meas_ack_i;
    logic             meas_valid_o;
    logic [CNT_W-1:0] meas_period_o;
    logic [CNT_W-1:0] meas_high_o;
    logic             overflow_o;
    logic             overrun_o;
    logic             stall_o;

    clk_period_meter #(.CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sig_i         (sig_i),
        .meas_ack_i    (meas_ack_i),
        .meas_valid_o  (meas_valid_o),
        .meas_period_o (meas_period_o),
        .meas_high_o   (meas_high_o),
        .overflow_o    (overflow_o),
        .overrun_o     (overrun_o),
        .stall_o       (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int   cur_len;
    int   cur_high;
    bit   have_prev;
    bit   last_sig;
    bit   hold;
    int   hold_pushes;
    int   ack_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A rise closes the previous interval: queue its expected result
    task automatic note_rise();
        exp_t e;
        if (have_prev) begin
            e.period = CNT_W'((cur_len > MAXV) ? MAXV : cur_len);
            e.high   = CNT_W'((cur_high > MAXV) ? MAXV : cur_high);
            e.ovf    = (cur_len > MAXV);
            e.ovr    = 1'b0;
            if (hold && hold_pushes > 0) begin
                e.ovr = 1'b1;
                q[q.size()-1] = e;
            end else begin
                q.push_back(e);
            end
            if (hold) hold_pushes++;
        end
        have_prev = 1'b1;
        cur_len   = 0;
        cur_high  = 0;
    endtask

    task automatic step(input logic v);
        sig_i = v;
        if (v && !last_sig) note_rise();
        cur_len++;
        if (v) cur_high++;
        last_sig = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        for (int i = 0; i < h; i++) step(1'b1);
        for (int i = 0; i < l; i++) step(1'b0);
    endtask

    // Hold sig_i low until every queued result has been consumed
    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) step(1'b0);
        check("drain_queue_empty", q.size(), 0);
        step(1'b0);
        step(1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        cur_len     = 0;
        cur_high    = 0;
        have_prev   = 1'b0;
        last_sig    = 1'b0;
        hold_pushes = 0;
    endtask

    // Monitor/consumer: acks ack_delay cycles after a result appears, checking it
    initial begin
        int   wcnt;
        exp_t e;
        meas_ack_i = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                meas_ack_i = 1'b0;
                wcnt = 0;
            end else begin
                if (meas_ack_i) begin
                    meas_ack_i = 1'b0;
                    wcnt = 0;
                end
                if (meas_valid_o && !hold) begin
                    if (wcnt >= ack_delay) begin
                        if (q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_result: got period %0d high %0d, expected none pending",
                                     meas_period_o, meas_high_o);
                        end else begin
                            e = q.pop_front();
                            check("period",   meas_period_o, e.period);
                            check("high",     meas_high_o,   e.high);
                            check("overflow", overflow_o,    e.ovf);
                            check("overrun",  overrun_o,     e.ovr);
                            check("stall",    stall_o,       0);
                        end
                        meas_ack_i = 1'b1;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i     = 1'b1;
        sig_i     = 1'b0;
        hold      = 1'b0;
        ack_delay = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid",    meas_valid_o,  0);
        check("rst_period",   meas_period_o, 0);
        check("rst_high",     meas_high_o,   0);
        check("rst_overflow", overflow_o,    0);
        check("rst_overrun",  overrun_o,     0);
        check("rst_stall",    stall_o,       0);
        rst_i = 1'b0;
        step(1'b0);
        step(1'b0);

        // Basic shapes: 10/5, 7/2, minimum period 2
        repeat (6) pulse(5, 5);
        repeat (6) pulse(2, 5);
        repeat (8) pulse(1, 1);

        // Long high interval saturates, then fast pulses recover
        pulse(300, 1);
        repeat (6) pulse(1, 1);

        // No ack across several captures: overwrite sets overrun
        drain();
        hold = 1'b1;
        hold_pushes = 0;
        repeat (3) pulse(5, 5);
        hold = 1'b0;
        repeat (4) step(1'b0);
        repeat (3) pulse(5, 5);

        // Ack lands on the capture edge: valid stays, no overrun
        drain();
        ack_delay = 9;
        repeat (6) pulse(5, 5);
        drain();
        ack_delay = 0;

        // Asynchronous reset mid-period with a result pending
        hold = 1'b1;
        hold_pushes = 0;
        repeat (3) pulse(4, 4);
        step(1'b0);
        check("prereset_valid", meas_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_valid",    meas_valid_o,  0);
        check("async_rst_period",   meas_period_o, 0);
        check("async_rst_high",     meas_high_o,   0);
        check("async_rst_overflow", overflow_o,    0);
        check("async_rst_overrun",  overrun_o,     0);
        check("async_rst_stall",    stall_o,       0);
        sig_i = 1'b0;
        model_reset();
        hold = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(1'b0);
        // First post-reset rise only arms; a result must not appear yet
        pulse(3, 3);
        check("post_reset_no_result", meas_valid_o, 0);
        repeat (3) pulse(3, 3);

        // Randomised pulse train
        for (int n = 0; n < 150; n++) begin
            pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
        end

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
